// File: rtl/offset_generator_if.sv
// Config, enable and offset bundle for offset_generator.
// master drives config/enable; slave returns the offset.
interface offset_generator_if;
  logic [7:0]  io_num;
  logic [31:0] io_range;
  logic [31:0] io_step;
  logic        io_en;
  logic [31:0] io_offset;

  modport master (
    output io_num,
    output io_range,
    output io_step,
    output io_en,
    input  io_offset
  );

  modport slave (
    input  io_num,
    input  io_range,
    input  io_step,
    input  io_en,
    output io_offset
  );
endinterface

// File: rtl/offset_generator.sv
// Round-robin interleaved lane offset stream.
// Each round steps a shared in-window offset.
module offset_generator (
  input  logic              clock,
  input  logic              reset,
  offset_generator_if.slave io
);

  logic [7:0]  lane_idx;
  logic [31:0] lane_base;
  logic [31:0] round_off;

  logic [7:0]  lane_idx_nx;
  logic [31:0] lane_base_nx;
  logic [31:0] round_off_nx;

  logic [7:0]  last_idx;
  logic        last;
  logic [32:0] sum;
  logic        wrap;

  assign last_idx = (io.io_num == 8'd0) ? 8'd0
                  : io.io_num - 8'd1;
  assign last     = lane_idx >= last_idx;

  // Carry out counts as a wrap too.
  assign sum  = {1'b0, round_off} + {1'b0, io.io_step};
  assign wrap = sum[32] | (sum[31:0] >= io.io_range);

  always_comb begin
    lane_idx_nx  = lane_idx;
    lane_base_nx = lane_base;
    round_off_nx = round_off;
    if (io.io_en) begin
      if (last) begin
        lane_idx_nx  = 8'd0;
        lane_base_nx = 32'd0;
        round_off_nx = wrap ? 32'd0 : sum[31:0];
      end else begin
        lane_idx_nx  = lane_idx + 8'd1;
        lane_base_nx = lane_base + io.io_range;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lane_idx  <= 8'd0;
      lane_base <= 32'd0;
      round_off <= 32'd0;
    end else begin
      lane_idx  <= lane_idx_nx;
      lane_base <= lane_base_nx;
      round_off <= round_off_nx;
    end
  end

  assign io.io_offset = lane_base + round_off;

endmodule

// File: tb/tb_offset_generator.sv
// Directed bench for offset_generator.
// Offsets are checked 1ns after each rising edge.
module tb_offset_generator;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  offset_generator_if io ();

  offset_generator dut (
    .clock (clock),
    .reset (reset),
    .io    (io.slave)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [7:0] n,
                     input logic [31:0] r,
                     input logic [31:0] s);
    io.io_num   = n;
    io.io_range = r;
    io.io_step  = s;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    io.io_en = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] exp;
  logic [31:0] ring4 [4];

  initial begin
    reset = 1'b1;
    io.io_en = 1'b0;
    cfg(8'h5a, 32'hdead_beef, 32'h1234_5678);
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("reset_hold", io.io_offset, 32'h0);
    end
    reset = 1'b0;
    cfg(8'd8, 32'h1000, 32'd32);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle", io.io_offset, 32'h0);
    end

    // interleave + window wrap, one period plus 20 positions
    io.io_en = 1'b1;
    for (int p = 0; p < 1024 + 20; p++) begin
      exp = ((p % 8) * 32'h1000) + (((p / 8) % 128) * 32);
      if (p == 1023)
        chk("last_7fe0", io.io_offset, 32'h7fe0);
      else if (p == 1024)
        chk("period_wrap", io.io_offset, 32'h0);
      else
        chk("interleave", io.io_offset, exp);
      if (p == 1024 + 19) break;
      tick();
    end

    chk("pause_at", io.io_offset, 32'h3040);
    io.io_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("pause_hold", io.io_offset, 32'h3040);
    end
    io.io_en = 1'b1;
    tick();
    chk("resume", io.io_offset, 32'h4040);

    // single lane, then num=0
    ring4 = '{32'h0, 32'h40, 32'h80, 32'hc0};
    for (int k = 0; k < 2; k++) begin
      cfg((k == 0) ? 8'd1 : 8'd0, 32'h100, 32'h40);
      do_reset();
      io.io_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
        chk(k == 0 ? "num1" : "num0", io.io_offset, ring4[i % 4]);
        tick();
      end
    end

    // step past range: round_off pinned at 0
    cfg(8'd2, 32'h1000, 32'h2000);
    do_reset();
    io.io_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("alt", io.io_offset, (i % 2 == 0) ? 32'h0 : 32'h1000);
      tick();
    end
    chk("pre_sreset", io.io_offset, 32'h0);
    reset = 1'b1;
    tick();
    chk("sreset_en", io.io_offset, 32'h0);
    reset = 1'b0;
    tick();
    chk("after_sreset", io.io_offset, 32'h1000);

    // 32-bit add overflow forces a wrap
    cfg(8'd1, 32'hffff_ffff, 32'h9000_0000);
    do_reset();
    io.io_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf", io.io_offset,
          (i % 2 == 0) ? 32'h0 : 32'h9000_0000);
      tick();
    end

    // range 0: always at lane bases only
    cfg(8'd1, 32'h0, 32'h10);
    do_reset();
    io.io_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("range0", io.io_offset, 32'h0);
    end

    // lane count shrinks below current lane
    cfg(8'd8, 32'h100, 32'h10);
    do_reset();
    io.io_en = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("pre_shrink", io.io_offset, 32'h500);
    io.io_num = 8'd2;
    tick();
    chk("shrink", io.io_offset, 32'h10);
    tick();
    chk("shrink_next", io.io_offset, 32'h110);

    io.io_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
